rom_stream_reader: RTL and testbench

ROM_STREAM_READER -- requirements
Module: rom_stream_reader

---
 rtl/rom_stream_reader_pkg.sv | 14 +
 rtl/rs_fifo.sv | 56 +++++
 rtl/rom_stream_reader.sv | 121 ++++++++++++
 tb/tb_rom_stream_reader.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/rom_stream_reader_pkg.sv
// Shared types and default sizing for the ROM burst streamer.
package rom_stream_reader_pkg;

  localparam int DEF_AW         = 10;
  localparam int DEF_DW         = 32;
  localparam int DEF_FIFO_DEPTH = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2
  } state_t;

endpackage

// File: rtl/rs_fifo.sv
// Synchronous FIFO holding ROM words plus their end-of-burst tag.
module rs_fifo #(
  parameter int DW    = 32,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wr_en,
  input  logic [DW:0]              wr_data,
  input  logic                     rd_en,
  output logic [DW:0]              rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [DW:0]    r_mem [DEPTH];
  logic [PW-1:0]  r_wr_ptr;
  logic [PW-1:0]  r_rd_ptr;
  logic [CW-1:0]  r_count;
  logic           w_push;
  logic           w_pop;

  // A pop frees the slot the same cycle, so a push into a full FIFO is fine then.
  assign w_pop  = rd_en && (r_count != '0);
  assign w_push = wr_en && ((r_count != CW'(DEPTH)) || w_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= wr_data;
  end

  assign rd_data = r_mem[r_rd_ptr];
  assign full    = (r_count == CW'(DEPTH));
  assign empty   = (r_count == '0);
  assign count   = r_count;

endmodule

// File: rtl/rom_stream_reader.sv
// Reads a burst of consecutive ROM words and streams them out through a
// small credit-protected FIFO with valid/ready handshake.
module rom_stream_reader
  import rom_stream_reader_pkg::*;
#(
  parameter int AW         = DEF_AW,
  parameter int DW         = DEF_DW,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [AW-1:0] start_addr,
  input  logic [AW-1:0] length,
  output logic          busy,
  output logic          done,
  output logic          rom_ce,
  output logic [AW-1:0] rom_addr,
  input  logic [DW-1:0] rom_dout,
  output logic          m_valid,
  input  logic          m_ready,
  output logic [DW-1:0] m_data,
  output logic          m_last
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  state_t        r_state;
  state_t        w_next_state;
  logic [AW-1:0] r_addr;
  logic [AW-1:0] r_remaining;
  logic          r_inflight;
  logic          r_inflight_last;
  logic          r_done;

  logic          w_rom_ce;
  logic          w_final_issue;
  logic          w_start_burst;
  logic          w_start_empty;
  logic          w_accept;
  logic          w_accept_last;
  logic [CW-1:0] w_fifo_count;
  logic          w_fifo_full;
  logic          w_fifo_empty;
  logic [DW:0]   w_fifo_head;
  logic [CW:0]   w_credit_used;

  // Slots already claimed: words sitting in the FIFO plus the read in flight.
  assign w_credit_used = {1'b0, w_fifo_count} + {{CW{1'b0}}, r_inflight};
  assign w_start_burst = (r_state == IDLE) && start && (length != '0);
  assign w_start_empty = (r_state == IDLE) && start && (length == '0);
  assign w_accept      = !w_fifo_empty && m_ready;
  assign w_accept_last = w_accept && w_fifo_head[DW];
  assign w_final_issue = w_rom_ce && (r_remaining == AW'(1));

  always_comb begin
    w_next_state = r_state;
    w_rom_ce     = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_start_burst) w_next_state = FETCH;
      end
      FETCH: begin
        w_rom_ce = !w_fifo_full && (w_credit_used < (CW+1)'(FIFO_DEPTH));
        if (w_rom_ce && (r_remaining == AW'(1))) w_next_state = DRAIN;
      end
      DRAIN: begin
        if (w_accept_last) w_next_state = IDLE;
      end
      default: w_next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state         <= IDLE;
      r_addr          <= '0;
      r_remaining     <= '0;
      r_inflight      <= 1'b0;
      r_inflight_last <= 1'b0;
      r_done          <= 1'b0;
    end else begin
      r_state         <= w_next_state;
      r_inflight      <= w_rom_ce;
      r_inflight_last <= w_final_issue;
      r_done          <= w_start_empty || ((r_state == DRAIN) && w_accept_last);
      if (w_start_burst) begin
        r_addr      <= start_addr;
        r_remaining <= length;
      end else if (w_rom_ce) begin
        r_addr      <= r_addr + 1'b1;
        r_remaining <= r_remaining - 1'b1;
      end
    end
  end

  // ROM data for last cycle's read lands here, tagged if it ended the burst.
  rs_fifo #(
    .DW    (DW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (r_inflight),
    .wr_data ({r_inflight_last, rom_dout}),
    .rd_en   (m_ready),
    .rd_data (w_fifo_head),
    .full    (w_fifo_full),
    .empty   (w_fifo_empty),
    .count   (w_fifo_count)
  );

  assign busy     = (r_state != IDLE);
  assign done     = r_done;
  assign rom_ce   = w_rom_ce;
  assign rom_addr = r_addr;
  assign m_valid  = !w_fifo_empty;
  assign m_data   = w_fifo_head[DW-1:0];
  assign m_last   = w_fifo_head[DW] && !w_fifo_empty;

endmodule

// File: tb/tb_rom_stream_reader.sv
// Directed self-checking bench for rom_stream_reader with a synchronous ROM model.
module tb_rom_stream_reader;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [9:0]  start_addr;
  logic [9:0]  length;
  logic        busy;
  logic        done;
  logic        rom_ce;
  logic [9:0]  rom_addr;
  logic [31:0] rom_dout;
  logic        m_valid;
  logic        m_ready;
  logic [31:0] m_data;
  logic        m_last;

  int checksTotal  = 0;
  int checksPassed = 0;

  rom_stream_reader dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .start_addr (start_addr),
    .length     (length),
    .busy       (busy),
    .done       (done),
    .rom_ce     (rom_ce),
    .rom_addr   (rom_addr),
    .rom_dout   (rom_dout),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .m_data     (m_data),
    .m_last     (m_last)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] romWord(input logic [9:0] a);
    return {6'h2B, a, 6'h15, ~a};
  endfunction

  // Registered-address ROM: data appears the cycle after rom_ce.
  always @(posedge clk) begin
    if (rom_ce) rom_dout <= romWord(rom_addr);
  end

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checksTotal++;
    if (got !== exp)
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, got, exp);
    else
      checksPassed++;
  endtask

  // Pulses start for one cycle; returns at the falling edge of the first burst cycle.
  task automatic applyStimulus(input logic [9:0] addr, input logic [9:0] len);
    @(negedge clk);
    start      = 1'b1;
    start_addr = addr;
    length     = len;
    @(negedge clk);
    start = 1'b0;
  endtask

  // mode 0: ready always high; 1: ready low for stallCycles then high; 2: random ready with stray starts.
  task automatic runBurst(input logic [9:0] addr, input logic [9:0] len, input int mode, input int stallCycles);
    int         idx;
    int         ceCount;
    int         cyc;
    bit         finished;
    logic [9:0] ea;
    idx = 0; ceCount = 0; cyc = 0; finished = 0;
    m_ready = 1'b0;
    applyStimulus(addr, len);
    while (!finished && cyc < 2000) begin
      cyc++;
      if (cyc > 1) @(negedge clk);
      case (mode)
        0:       m_ready = 1'b1;
        1:       m_ready = (cyc > stallCycles);
        default: m_ready = 1'($urandom_range(0, 1));
      endcase
      if (mode == 2) begin
        start      = ($urandom_range(0, 3) == 0) && !m_last;
        start_addr = 10'h200;
        length     = 10'd5;
      end
      if (rom_ce) begin
        ea = addr + ceCount[9:0];
        checkOutput("ceAddr", rom_addr, ea);
        ceCount++;
      end
      if (stallCycles > 0 && cyc == stallCycles)
        checkOutput("stallCe", ceCount, 4);
      if (m_valid && m_ready) begin
        ea = addr + idx[9:0];
        checkOutput("data", m_data, romWord(ea));
        checkOutput("last", m_last, (idx == int'(len) - 1));
        idx++;
        if (m_last) finished = 1;
      end
    end
    start = 1'b0;
    if (!finished) checkOutput("timeout", 0, 1);
    checkOutput("wordCount", idx, len);
    checkOutput("ceCount", ceCount, len);
    @(negedge clk);
    checkOutput("doneAfter", done, 1);
    checkOutput("idleAfter", busy, 0);
    @(negedge clk);
    checkOutput("doneOnce", done, 0);
  endtask

  initial begin
    rst_n      = 1'b0;
    start      = 1'b0;
    start_addr = '0;
    length     = '0;
    m_ready    = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("rstBusy", busy, 0);
    checkOutput("rstDone", done, 0);
    checkOutput("rstCe", rom_ce, 0);
    checkOutput("rstAddr", rom_addr, 0);
    checkOutput("rstValid", m_valid, 0);
    checkOutput("rstLast", m_last, 0);
    rst_n = 1'b1;
    @(negedge clk);

    $display("[TB] basic burst timing");
    m_ready = 1'b1;
    applyStimulus(10'h010, 10'd4);
    for (int c = 1; c <= 7; c++) begin
      if (c > 1) @(negedge clk);
      checkOutput($sformatf("t1Ce%0d", c), rom_ce, (c <= 4));
      if (c <= 4) checkOutput($sformatf("t1Addr%0d", c), rom_addr, 10'(16 + c - 1));
      checkOutput($sformatf("t1Valid%0d", c), m_valid, (c >= 3 && c <= 6));
      if (c >= 3 && c <= 6) begin
        checkOutput($sformatf("t1Data%0d", c), m_data, romWord(10'(16 + c - 3)));
        checkOutput($sformatf("t1Last%0d", c), m_last, (c == 6));
      end
      checkOutput($sformatf("t1Done%0d", c), done, (c == 7));
      checkOutput($sformatf("t1Busy%0d", c), busy, (c <= 6));
    end

    $display("[TB] address wrap");
    runBurst(10'h3FE, 10'd4, 0, 0);

    $display("[TB] empty burst");
    m_ready = 1'b1;
    applyStimulus(10'h055, 10'd0);
    checkOutput("emptyDone", done, 1);
    checkOutput("emptyBusy", busy, 0);
    checkOutput("emptyCe", rom_ce, 0);
    checkOutput("emptyValid", m_valid, 0);
    @(negedge clk);
    checkOutput("emptyDoneOnce", done, 0);
    checkOutput("emptyBusy2", busy, 0);
    checkOutput("emptyCe2", rom_ce, 0);

    $display("[TB] backpressure stall");
    runBurst(10'h040, 10'd16, 1, 20);

    $display("[TB] reset mid-burst");
    m_ready = 1'b0;
    applyStimulus(10'h100, 10'd8);
    repeat (3) @(negedge clk);
    checkOutput("preRstValid", m_valid, 1);
    rst_n = 1'b0;
    #1;
    checkOutput("midRstValid", m_valid, 0);
    checkOutput("midRstBusy", busy, 0);
    checkOutput("midRstCe", rom_ce, 0);
    checkOutput("midRstAddr", rom_addr, 0);
    @(negedge clk);
    rst_n = 1'b1;
    runBurst(10'h020, 10'd2, 0, 0);

    $display("[TB] random ready long burst");
    runBurst(10'h080, 10'd64, 2, 0);

    $display("%0d/%0d checks passed", checksPassed, checksTotal);
    $finish;
  end

endmodule
